// File: rtl/plant_emulator.sv
// Deterministic plant model driven by the main FSM's actuator commands.
// Tank level, motor spin-up and run time are tracked and reported as registered sensor flags.
module plant_emulator #(
  parameter int LEVEL_W   = 4,
  parameter int LEVEL_MAX = 12,
  parameter int STEP_DIV  = 4,
  parameter int SPINUP    = 3,
  parameter int RUN_TICKS = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               MOTOR,
  input  logic               EV,
  input  logic               VE,
  input  logic               ALARME,
  input  logic               door_in,
  input  logic               fault_ro,
  output logic               PG,
  output logic               CH,
  output logic               RO,
  output logic               CQ,
  output logic               EB,
  output logic [LEVEL_W-1:0] level,
  output logic               alarm_seen
);

  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int SPIN_W = (SPINUP > 0) ? $clog2(SPINUP + 1) : 1;
  localparam int RUN_W  = (RUN_TICKS > 0) ? $clog2(RUN_TICKS + 1) : 1;

  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [LEVEL_W-1:0] LVL_FULL  = LEVEL_W'(LEVEL_MAX);
  localparam logic [SPIN_W-1:0]  SPIN_SAT  = SPIN_W'(SPINUP);
  localparam logic [RUN_W-1:0]   RUN_SAT   = RUN_W'(RUN_TICKS);

  logic               r_door_meta;
  logic               r_door_sync;
  logic [1:0]         r_dir;
  logic [STEP_W-1:0]  r_step;
  logic [LEVEL_W-1:0] r_level;
  logic [SPIN_W-1:0]  r_spin;
  logic [RUN_W-1:0]   r_run;
  logic               r_ch;
  logic               r_eb;
  logic               r_ro;
  logic               r_cq;
  logic               r_alarm;

  logic [1:0]         w_dir;
  logic               w_sat;
  logic [STEP_W-1:0]  w_step_eff;
  logic [STEP_W-1:0]  w_step_next;
  logic [LEVEL_W-1:0] w_level_next;
  logic [SPIN_W-1:0]  w_spin_next;
  logic [RUN_W-1:0]   w_run_next;
  logic               w_run_clear;

  // Bit 0 = filling, bit 1 = draining; both valves open cancels out to hold.
  assign w_dir = {VE & ~EV, EV & ~VE};
  assign w_sat = (w_dir[0] && (r_level == LVL_FULL)) ||
                 (w_dir[1] && (r_level == '0));
  // A direction reversal restarts the step count as if from idle.
  assign w_step_eff  = (w_dir != r_dir) ? '0 : r_step;
  assign w_run_clear = r_eb & ~MOTOR & ~EV;

  // Level stepping: one unit per STEP_DIV active cycles, clamped at both ends.
  always_comb begin
    w_step_next  = r_step;
    w_level_next = r_level;
    if ((w_dir == 2'b00) || w_sat) begin
      w_step_next = '0;
    end else if (w_step_eff == STEP_LAST) begin
      w_step_next = '0;
      if (w_dir[0]) begin
        w_level_next = r_level + LEVEL_W'(1);
      end else begin
        w_level_next = r_level - LEVEL_W'(1);
      end
    end else begin
      w_step_next = w_step_eff + STEP_W'(1);
    end
  end

  // Spin-up and accumulated run time.
  always_comb begin
    w_spin_next = '0;
    w_run_next  = r_run;
    if (MOTOR) begin
      w_spin_next = (r_spin == SPIN_SAT) ? r_spin : r_spin + SPIN_W'(1);
    end else begin
      w_spin_next = '0;
    end
    if (w_run_clear) begin
      w_run_next = '0;
    end else if (MOTOR && (r_run != RUN_SAT)) begin
      w_run_next = r_run + RUN_W'(1);
    end else begin
      w_run_next = r_run;
    end
  end

  // Plant state and registered sensor flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_door_meta <= 1'b0;
      r_door_sync <= 1'b0;
      r_dir       <= 2'b00;
      r_step      <= '0;
      r_level     <= '0;
      r_spin      <= '0;
      r_run       <= '0;
      r_ch        <= 1'b0;
      r_eb        <= 1'b1;
      r_ro        <= 1'b0;
      r_cq        <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      r_door_meta <= door_in;
      r_door_sync <= r_door_meta;
      r_dir       <= w_dir;
      r_step      <= w_step_next;
      r_level     <= w_level_next;
      r_spin      <= w_spin_next;
      r_run       <= w_run_next;
      r_ch        <= (w_level_next == LVL_FULL);
      r_eb        <= (w_level_next == '0);
      r_ro        <= (w_spin_next == SPIN_SAT) && !fault_ro;
      r_cq        <= (w_run_next == RUN_SAT);
      r_alarm     <= r_alarm | ALARME;
    end
  end

  assign PG         = r_door_sync;
  assign CH         = r_ch;
  assign EB         = r_eb;
  assign RO         = r_ro;
  assign CQ         = r_cq;
  assign level      = r_level;
  assign alarm_seen = r_alarm;

endmodule

// File: tb/tb_plant_emulator.sv
// Directed bench for plant_emulator: a cycle model checked every negedge,
// plus literal checkpoints from the test plan.
module tb_plant_emulator;

  localparam int LMAX = 12;
  localparam int SDIV = 4;
  localparam int SPIN = 3;
  localparam int RUNT = 16;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic       MOTOR, EV, VE, ALARME, door_in, fault_ro;
  logic       PG, CH, RO, CQ, EB, alarm_seen;
  logic [3:0] level;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  cmp_en   = 1'b0;

  // Model state: physical quantities, not RTL registers.
  int  m_level;
  int  m_cycles_in_dir;
  int  m_dir;
  int  m_motor_streak;
  int  m_motor_total;
  bit  m_door_a, m_door_b;
  bit  m_ro;
  bit  m_alarm;

  plant_emulator dut (
    .clock(clock), .reset_n(reset_n), .MOTOR(MOTOR), .EV(EV), .VE(VE),
    .ALARME(ALARME), .door_in(door_in), .fault_ro(fault_ro),
    .PG(PG), .CH(CH), .RO(RO), .CQ(CQ), .EB(EB), .level(level),
    .alarm_seen(alarm_seen)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_cycles_in_dir = 0; m_dir = 0;
    m_motor_streak = 0; m_motor_total = 0;
    m_door_a = 1'b0; m_door_b = 1'b0; m_ro = 1'b0; m_alarm = 1'b0;
  endtask

  // One clock of plant physics using the inputs the DUT just sampled.
  task automatic model_step();
    int  dir;
    bit  was_empty;
    was_empty = (m_level == 0);
    dir = (EV && !VE) ? 1 : ((VE && !EV) ? -1 : 0);
    if (dir == 0 || (dir == 1 && m_level == LMAX) || (dir == -1 && m_level == 0)) begin
      m_cycles_in_dir = 0;
    end else begin
      if (dir != m_dir) m_cycles_in_dir = 0;
      m_cycles_in_dir++;
      if (m_cycles_in_dir == SDIV) begin
        m_level += dir;
        m_cycles_in_dir = 0;
      end
    end
    m_dir = dir;
    m_motor_streak = MOTOR ? m_motor_streak + 1 : 0;
    m_ro = (m_motor_streak >= SPIN) && !fault_ro;
    if (was_empty && !MOTOR && !EV) m_motor_total = 0;
    else if (MOTOR) m_motor_total++;
    m_door_b = m_door_a;
    m_door_a = door_in;
    m_alarm = m_alarm | ALARME;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      model_step();
      #1;
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("cyc_level", 32'(level), m_level);
      chk("cyc_CH", 32'(CH), int'(m_level == LMAX));
      chk("cyc_EB", 32'(EB), int'(m_level == 0));
      chk("cyc_RO", 32'(RO), int'(m_ro));
      chk("cyc_CQ", 32'(CQ), int'(m_motor_total >= RUNT));
      chk("cyc_PG", 32'(PG), int'(m_door_b));
      chk("cyc_alarm", 32'(alarm_seen), int'(m_alarm));
    end
  end

  initial begin
    MOTOR = 1'b0; EV = 1'b0; VE = 1'b0; ALARME = 1'b0; door_in = 1'b0; fault_ro = 1'b0;
    #1 reset_n = 1'b0;
    model_reset();
    cmp_en = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Reset mid-fill at level 5.
    EV = 1'b1;
    tick(20);
    chk("prefill_level", 32'(level), 5);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_EB", 32'(EB), 1);
    chk("rst_CH", 32'(CH), 0);
    chk("rst_RO", 32'(RO), 0);
    chk("rst_CQ", 32'(CQ), 0);
    chk("rst_PG", 32'(PG), 0);
    chk("rst_alarm", 32'(alarm_seen), 0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Fill to saturation.
    tick(3);
    chk("fill_c3", 32'(level), 0);
    tick(1);
    chk("fill_c4", 32'(level), 1);
    tick(44);
    chk("fill_c48", 32'(level), 12);
    chk("fill_CH", 32'(CH), 1);
    tick(8);
    chk("fill_sat", 32'(level), 12);

    // Drain two units, then hold with both valves open.
    EV = 1'b0; VE = 1'b1;
    tick(8);
    chk("drain8", 32'(level), 10);
    EV = 1'b1;
    tick(8);
    chk("hold8", 32'(level), 10);
    EV = 1'b0; VE = 1'b1;
    tick(3);
    chk("step_cleared", 32'(level), 10);
    tick(1);
    chk("drain_after_hold", 32'(level), 9);
    VE = 1'b0;

    // Run accumulation across a motor stop.
    MOTOR = 1'b1; tick(10);
    MOTOR = 1'b0; tick(5);
    MOTOR = 1'b1; tick(5);
    chk("cq_15", 32'(CQ), 0);
    tick(1);
    chk("cq_16", 32'(CQ), 1);
    MOTOR = 1'b0; VE = 1'b1;
    tick(36);
    chk("empty_level", 32'(level), 0);
    chk("empty_EB", 32'(EB), 1);
    chk("cq_held", 32'(CQ), 1);
    tick(1);
    chk("cq_clear", 32'(CQ), 0);
    VE = 1'b0;

    // Spin-up and fault injection.
    MOTOR = 1'b1;
    tick(2);
    chk("ro_2", 32'(RO), 0);
    tick(1);
    chk("ro_3", 32'(RO), 1);
    tick(2);
    chk("ro_5", 32'(RO), 1);
    fault_ro = 1'b1; tick(1);
    chk("ro_fault", 32'(RO), 0);
    fault_ro = 1'b0; tick(1);
    chk("ro_unfault", 32'(RO), 1);
    MOTOR = 1'b0; tick(1);
    chk("ro_stop", 32'(RO), 0);

    // Door synchronizer latency.
    door_in = 1'b1; tick(1);
    chk("pg_rise1", 32'(PG), 0);
    tick(1);
    chk("pg_rise2", 32'(PG), 1);
    door_in = 1'b0; tick(1);
    chk("pg_fall1", 32'(PG), 1);
    tick(1);
    chk("pg_fall2", 32'(PG), 0);

    // Sticky alarm.
    ALARME = 1'b1; tick(1);
    chk("alarm_set", 32'(alarm_seen), 1);
    ALARME = 1'b0; tick(3);
    chk("alarm_sticky", 32'(alarm_seen), 1);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("alarm_rst", 32'(alarm_seen), 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick(2);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
